// File: rtl/lzrw1_pkg.sv
// Shared LZRW1 definitions: array capacity, token field widths, decoder
// state encoding and header-byte field extraction.
package lzrw1_pkg;

    localparam int unsigned STRINGSIZE = 4096;
    localparam int unsigned ADDRW      = $clog2(STRINGSIZE);
    localparam int unsigned CNT_W      = ADDRW + 1;
    localparam int unsigned LEN_W      = 4;
    localparam int unsigned OFF_W      = 12;
    localparam int unsigned OFF_HI_W   = OFF_W - 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_FETCH_LO,
        S_DECODE_LO,
        S_EMIT_LIT,
        S_COPY,
        S_DONE,
        S_ERR
    } state_e;

    // First byte of a copy token: {length, offset[11:8]}
    typedef struct packed {
        logic [LEN_W-1:0]    len;
        logic [OFF_HI_W-1:0] off_hi;
    } tok_hdr_t;

    function automatic tok_hdr_t split_hdr(input logic [7:0] b);
        return tok_hdr_t'(b);
    endfunction

endpackage

// File: rtl/lzrw1_decompressor_if.sv
// Reconstructed-byte stream (valid/ready).
//   outValid : byte on outByte is valid (producer -> consumer)
//   outByte  : reconstructed byte
//   outReady : consumer accepts the byte this cycle
interface lzrw1_decompressor_if;
    logic       outValid;
    logic [7:0] outByte;
    logic       outReady;

    modport master (output outValid, output outByte, input outReady);
    modport slave  (input outValid, input outByte, output outReady);
endinterface

// File: rtl/lzrw1_history_buffer.sv
// Reconstructed-output history: STRINGSIZE x 8 array, one synchronous write
// port and one combinational read port. Contents are deliberately not reset.
//   clock   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_c : read data (combinational)
module lzrw1_history_buffer
    import lzrw1_pkg::*;
(
    input  logic             clock,
    input  logic             we_i,
    input  logic [ADDRW-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic [ADDRW-1:0] raddr_i,
    output logic [7:0]       rdata_c
);

    logic [7:0] mem_q [STRINGSIZE];

    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/lzrw1_decompressor.sv
// LZRW1 decoder: walks the control-bit and compressed-byte arrays, expands
// literals and {length, offset} copy tokens, streams bytes out on out_if.
//   clock, reset       : clock, synchronous active-high reset
//   start, tokenCount  : start pulse and number of tokens to decode
//   ctrlAddr, ctrlBit  : control-array read port (1-cycle latency)
//   compAddr, compData : compressed-array read port (1-cycle latency)
//   out_if             : reconstructed byte stream
//   outCount           : bytes emitted since start
//   busy, done, error  : status levels
module lzrw1_decompressor
    import lzrw1_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [CNT_W-1:0]            tokenCount,
    output logic [ADDRW-1:0]            ctrlAddr,
    input  logic                        ctrlBit,
    output logic [ADDRW-1:0]            compAddr,
    input  logic [7:0]                  compData,
    lzrw1_decompressor_if.master        out_if,
    output logic [CNT_W-1:0]            outCount,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(STRINGSIZE);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   tok_idx_q, tok_idx_d;
    logic [CNT_W-1:0]   tok_cnt_q, tok_cnt_d;
    logic [CNT_W-1:0]   comp_ptr_q, comp_ptr_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [7:0]         out_byte_q, out_byte_d;
    logic               out_valid_q, out_valid_d;
    logic [ADDRW-1:0]   ctrl_addr_q, ctrl_addr_d;
    logic [ADDRW-1:0]   comp_addr_q, comp_addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               hist_we_c;
    logic [ADDRW-1:0]   hist_raddr_c;
    logic [7:0]         hist_rdata_c;
    logic               handshake_c;
    logic               token_end_c;
    logic [CNT_W-1:0]   tok_next_c;
    logic [OFF_W-1:0]   off_full_c;
    tok_hdr_t           hdr_c;

    lzrw1_history_buffer u_hist (
        .clock   (clock),
        .we_i    (hist_we_c),
        .waddr_i (out_count_q[ADDRW-1:0]),
        .wdata_i (out_byte_q),
        .raddr_i (hist_raddr_c),
        .rdata_c (hist_rdata_c)
    );

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tok_idx_q   <= '0;
            tok_cnt_q   <= '0;
            comp_ptr_q  <= '0;
            out_count_q <= '0;
            len_q       <= '0;
            off_q       <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
            ctrl_addr_q <= '0;
            comp_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tok_idx_q   <= tok_idx_d;
            tok_cnt_q   <= tok_cnt_d;
            comp_ptr_q  <= comp_ptr_d;
            out_count_q <= out_count_d;
            len_q       <= len_d;
            off_q       <= off_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            ctrl_addr_q <= ctrl_addr_d;
            comp_addr_q <= comp_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d      = state_q;
        tok_idx_d    = tok_idx_q;
        tok_cnt_d    = tok_cnt_q;
        comp_ptr_d   = comp_ptr_q;
        out_count_d  = out_count_q;
        len_d        = len_q;
        off_d        = off_q;
        out_byte_d   = out_byte_q;
        out_valid_d  = out_valid_q;
        ctrl_addr_d  = ctrl_addr_q;
        comp_addr_d  = comp_addr_q;
        hist_we_c    = 1'b0;
        token_end_c  = 1'b0;
        handshake_c  = out_valid_q && out_if.outReady;
        tok_next_c   = tok_idx_q + CNT_W'(1);
        hdr_c        = split_hdr(compData);
        off_full_c   = {off_q[OFF_W-1:8], compData};
        // Next copy source; the DECODE_LO branch overrides for the first byte
        hist_raddr_c = ADDRW'(out_count_q + CNT_W'(1) - CNT_W'(off_q));

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    tok_idx_d   = '0;
                    comp_ptr_d  = '0;
                    out_count_d = '0;
                    tok_cnt_d   = tokenCount;
                    ctrl_addr_d = '0;
                    comp_addr_d = '0;
                    state_d     = (tokenCount == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (!ctrlBit) begin
                    if (out_count_q == SIZE_C) begin
                        state_d = S_ERR;
                    end else begin
                        out_byte_d  = compData;
                        out_valid_d = 1'b1;
                        comp_ptr_d  = comp_ptr_q + CNT_W'(1);
                        state_d     = S_EMIT_LIT;
                    end
                end else if (hdr_c.len == '0 || comp_ptr_q + CNT_W'(1) >= SIZE_C) begin
                    state_d = S_ERR;
                end else begin
                    len_d       = hdr_c.len;
                    off_d       = {hdr_c.off_hi, 8'h00};
                    comp_addr_d = ADDRW'(comp_ptr_q + CNT_W'(1));
                    state_d     = S_FETCH_LO;
                end
            end
            S_FETCH_LO: state_d = S_DECODE_LO;
            S_DECODE_LO: begin
                hist_raddr_c = ADDRW'(out_count_q - CNT_W'(off_full_c));
                if (off_full_c == '0 || CNT_W'(off_full_c) > out_count_q ||
                    out_count_q + CNT_W'(len_q) > SIZE_C) begin
                    state_d = S_ERR;
                end else begin
                    off_d       = off_full_c;
                    comp_ptr_d  = comp_ptr_q + CNT_W'(2);
                    out_byte_d  = hist_rdata_c;
                    out_valid_d = 1'b1;
                    state_d     = S_COPY;
                end
            end
            S_EMIT_LIT: begin
                if (handshake_c) begin
                    hist_we_c   = 1'b1;
                    out_count_d = out_count_q + CNT_W'(1);
                    out_valid_d = 1'b0;
                    token_end_c = 1'b1;
                end
            end
            S_COPY: begin
                if (handshake_c) begin
                    hist_we_c   = 1'b1;
                    out_count_d = out_count_q + CNT_W'(1);
                    if (len_q > LEN_W'(1)) begin
                        len_d = len_q - LEN_W'(1);
                        // offset 1 reads the byte being written this cycle
                        out_byte_d = (off_q == OFF_W'(1)) ? out_byte_q : hist_rdata_c;
                    end else begin
                        out_valid_d = 1'b0;
                        token_end_c = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Token finished: advance to the next token, finish, or flag overrun
        if (token_end_c) begin
            tok_idx_d = tok_next_c;
            if (tok_next_c == tok_cnt_q) begin
                state_d = S_DONE;
            end else if (comp_ptr_q >= SIZE_C) begin
                state_d = S_ERR;
            end else begin
                ctrl_addr_d = ADDRW'(tok_next_c);
                comp_addr_d = ADDRW'(comp_ptr_q);
                state_d     = S_FETCH;
            end
        end

        busy_d  = !(state_d inside {S_IDLE, S_DONE, S_ERR});
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
    end

    assign ctrlAddr        = ctrl_addr_q;
    assign compAddr        = comp_addr_q;
    assign out_if.outValid = out_valid_q;
    assign out_if.outByte  = out_byte_q;
    assign outCount        = out_count_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;

endmodule

// File: tb/tb_lzrw1_decompressor.sv
module tb_lzrw1_decompressor;
    import lzrw1_pkg::*;

    logic             clock;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] tokenCount;
    logic [ADDRW-1:0] ctrlAddr;
    logic             ctrlBit;
    logic [ADDRW-1:0] compAddr;
    logic [7:0]       compData;
    logic [CNT_W-1:0] outCount;
    logic             busy, done, error;

    lzrw1_decompressor_if out_if ();

    lzrw1_decompressor dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .tokenCount (tokenCount),
        .ctrlAddr   (ctrlAddr),
        .ctrlBit    (ctrlBit),
        .compAddr   (compAddr),
        .compData   (compData),
        .out_if     (out_if),
        .outCount   (outCount),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Compressed-data memories with synchronous read
    logic       ctrl_mem [STRINGSIZE];
    logic [7:0] comp_mem [STRINGSIZE];

    always @(posedge clock) begin
        ctrlBit  <= ctrl_mem[ctrlAddr];
        compData <= comp_mem[compAddr];
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] got [$];
    int         stall_viol;
    int         valid_seen;
    int         last_cyc;
    int         first_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic c[$], input logic [7:0] d[$]);
        foreach (c[i]) ctrl_mem[i] = c[i];
        foreach (d[i]) comp_mem[i] = d[i];
    endtask

    task automatic do_start(input int n);
        @(negedge clock);
        tokenCount = CNT_W'(n);
        start      = 1'b1;
        @(negedge clock);
        start      = 1'b0;
    endtask

    // Run until done/error, recording handshaken bytes and stall stability
    task automatic collect(input bit toggle, input int budget);
        int         cyc = 0;
        logic [7:0] prev_byte = 8'h00;
        bit         prev_stall = 1'b0;
        got.delete();
        stall_viol  = 0;
        valid_seen  = 0;
        first_valid = -1;
        while (!(done || error) && cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (prev_stall && (!out_if.outValid || out_if.outByte !== prev_byte)) stall_viol++;
            out_if.outReady = toggle ? ~out_if.outReady : 1'b1;
            if (out_if.outValid) begin
                valid_seen++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (out_if.outValid && out_if.outReady) got.push_back(out_if.outByte);
            prev_stall = out_if.outValid && !out_if.outReady;
            prev_byte  = out_if.outByte;
        end
        last_cyc = cyc;
        check("finished_in_budget", 32'(cyc < budget), 32'd1);
    endtask

    task automatic check_stream(input string tag, input logic [7:0] exp[$]);
        logic [7:0] g;
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), 32'(g), 32'(exp[i]));
        end
    endtask

    initial begin
        int i;
        reset = 1'b1;
        start = 1'b0;
        tokenCount = '0;
        out_if.outReady = 1'b1;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_valid", 32'(out_if.outValid), 32'd0);
        check("rst_byte", 32'(out_if.outByte), 32'd0);
        check("rst_count", 32'(outCount), 32'd0);
        check("rst_flags", 32'({busy, done, error}), 32'd0);
        check("rst_addrs", 32'({ctrlAddr, compAddr}), 32'd0);
        reset = 1'b0;

        // Literal only
        load('{0, 0, 0}, '{8'h41, 8'h42, 8'h43});
        do_start(3);
        collect(1'b0, 100);
        check_stream("lit", '{8'h41, 8'h42, 8'h43});
        check("lit_first_valid", 32'(first_valid), 32'd2);
        check("lit_done_cyc", 32'(last_cyc), 32'd9);
        check("lit_flags", 32'({busy, done, error}), 32'b010);
        check("lit_count", 32'(outCount), 32'd3);

        // Simple match: ABC + copy(len 3, off 3)
        load('{0, 0, 0, 1}, '{8'h41, 8'h42, 8'h43, 8'h30, 8'h03});
        do_start(4);
        collect(1'b0, 100);
        check_stream("match", '{8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43});
        check("match_done_cyc", 32'(last_cyc), 32'd16);
        check("match_flags", 32'({busy, done, error}), 32'b010);
        check("match_count", 32'(outCount), 32'd6);

        // Overlapping copy: 'a' + copy(len 4, off 1)
        load('{0, 1}, '{8'h61, 8'h40, 8'h01});
        do_start(2);
        collect(1'b0, 100);
        check_stream("ovl", '{8'h61, 8'h61, 8'h61, 8'h61, 8'h61});
        check("ovl_flags", 32'({busy, done, error}), 32'b010);
        check("ovl_count", 32'(outCount), 32'd5);

        // Back-pressure on the simple match
        load('{0, 0, 0, 1}, '{8'h41, 8'h42, 8'h43, 8'h30, 8'h03});
        do_start(4);
        collect(1'b1, 200);
        out_if.outReady = 1'b1;
        check_stream("bp", '{8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43});
        check("bp_stall_stable", 32'(stall_viol), 32'd0);
        check("bp_count", 32'(outCount), 32'd6);
        check("bp_done", 32'(done), 32'd1);

        // Offset beyond history
        load('{1}, '{8'h30, 8'h05});
        do_start(1);
        collect(1'b0, 100);
        check("offbig_flags", 32'({busy, done, error}), 32'b001);
        check("offbig_novalid", 32'(valid_seen), 32'd0);
        check("offbig_cyc", 32'(last_cyc), 32'd4);
        check("offbig_count", 32'(outCount), 32'd0);

        // Zero length
        load('{1}, '{8'h00, 8'h01});
        do_start(1);
        collect(1'b0, 100);
        check("len0_flags", 32'({busy, done, error}), 32'b001);
        check("len0_cyc", 32'(last_cyc), 32'd2);
        check("len0_novalid", 32'(valid_seen), 32'd0);

        // Zero offset after one literal
        load('{0, 1}, '{8'h41, 8'h20, 8'h00});
        do_start(2);
        collect(1'b0, 100);
        check_stream("off0", '{8'h41});
        check("off0_flags", 32'({busy, done, error}), 32'b001);

        // tokenCount == 0
        do_start(0);
        check("zero_flags", 32'({busy, done, error}), 32'b010);
        valid_seen = 0;
        repeat (4) begin
            @(negedge clock);
            if (out_if.outValid) valid_seen++;
        end
        check("zero_novalid", 32'(valid_seen), 32'd0);
        check("zero_count", 32'(outCount), 32'd0);

        // Reset in the middle of a copy
        load('{0, 1}, '{8'h61, 8'h40, 8'h01});
        do_start(2);
        i = 0;
        while (!(out_if.outValid && outCount == CNT_W'(2)) && i < 50) begin
            @(negedge clock);
            i++;
        end
        check("midcopy_reached", 32'(out_if.outValid && outCount == CNT_W'(2)), 32'd1);
        check("midcopy_byte", 32'(out_if.outByte), 32'h61);
        reset = 1'b1;
        @(negedge clock);
        check("mrst_valid", 32'(out_if.outValid), 32'd0);
        check("mrst_byte", 32'(out_if.outByte), 32'd0);
        check("mrst_count", 32'(outCount), 32'd0);
        check("mrst_flags", 32'({busy, done, error}), 32'd0);
        check("mrst_addrs", 32'({ctrlAddr, compAddr}), 32'd0);
        reset = 1'b0;

        load('{0, 0, 0, 1}, '{8'h41, 8'h42, 8'h43, 8'h30, 8'h03});
        do_start(4);
        collect(1'b0, 100);
        check_stream("after_rst", '{8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43});
        check("after_rst_flags", 32'({busy, done, error}), 32'b010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lzrw1_decompressor.md
# lzrw1_decompressor

Decoder for the LZRW1 compressed format produced by the compressor's output stage. It walks the compressed byte array and control-bit array, expands literals and {length, offset} copy tokens, and streams reconstructed bytes out through a valid/ready port. It sits after the compressed-data memories and feeds the round-trip checker or any downstream byte consumer.

## Interface
- STRINGSIZE, 4096, capacity of the compressed array, control array and reconstructed output (bytes)
- ADDRW, $clog2(STRINGSIZE), address width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins decoding when idle
- tokenCount  in  ADDRW+1  number of control bits (tokens) to decode; sampled on start
- ctrlAddr  out  ADDRW  control-array read address
- ctrlBit  in  1  control bit at ctrlAddr, valid one cycle after address (synchronous read)
- compAddr  out  ADDRW  compressed-array read address
- compData  in  8  byte at compAddr, valid one cycle after address
- outValid  out  1  outByte valid
- outByte  out  8  reconstructed byte
- outReady  in  1  consumer accepts outByte when high with outValid
- outCount  out  ADDRW+1  bytes emitted since start
- busy  out  1  high from the cycle after start until DONE/ERR
- done  out  1  level; decode finished cleanly; cleared by start or reset
- error  out  1  level; malformed stream; cleared by start or reset

## Operation
- Token format: ctrl=0 -> one literal byte; ctrl=1 -> two bytes: byte0 = {length[3:0], offset[11:8]}, byte1 = offset[7:0].
- Copy count = length (1..15); source byte = history[outCount - offset]; copied bytes are emitted in increasing address order.
- Every emitted byte is written to history[outCount] on its handshake, so overlapping copies (offset < length) replicate correctly.
- States: IDLE, FETCH, DECODE, FETCH_LO, DECODE_LO, EMIT_LIT, COPY, DONE, ERR.
- IDLE: on start, clear tokIdx/compPtr/outCount, latch tokenCount; go to DONE if tokenCount==0, else FETCH.
- FETCH: drive ctrlAddr=tokIdx, compAddr=compPtr -> DECODE.
- DECODE: ctrlBit=0 -> latch compData into outByte, compPtr+=1 -> EMIT_LIT; ctrlBit=1 -> latch length/offset[11:8] -> FETCH_LO.
- FETCH_LO: drive compAddr=compPtr+1 -> DECODE_LO; DECODE_LO: latch offset[7:0], compPtr+=2 -> COPY.
- Errors (-> ERR, error=1, busy=0): length==0; offset==0; offset > outCount; any byte that would make outCount exceed STRINGSIZE; compPtr reaching STRINGSIZE before tokens are exhausted.
- EMIT_LIT/COPY: outValid=1; on handshake outCount+=1; after the token's last byte, tokIdx+=1 and go to DONE if tokIdx==tokenCount, else FETCH.
- DONE/ERR: hold until start (restarts) or reset.
- start while busy is ignored.

## Timing
- Reset: outValid, outByte, outCount, busy, done, error, ctrlAddr, compAddr all 0; state IDLE. History contents are not reset.
- Literal: outValid rises 2 cycles after entering FETCH.
- Match: first copy byte valid 4 cycles after entering FETCH; then one byte per cycle while outReady=1.
- outByte and outValid stay stable while outValid=1 and outReady=0.
- Copy pointer and outCount advance only on handshake cycles.
- done/error assert in the cycle after the final handshake or the detecting DECODE_LO/DECODE cycle.
- Reset mid-operation: next cycle is IDLE with all outputs at reset values; no partial byte is emitted.

## Structure
- Package lzrw1_pkg: STRINGSIZE default, state enum, token field widths (LEN_W=4, OFF_W=12), length/offset field extraction helpers. Share it with the compressor.
- Sub-module lzrw1_history_buffer: STRINGSIZE x 8 register array with one synchronous write port and one combinational read port.
- Decoder FSM and pointers stay in lzrw1_decompressor.

## Test plan
- Literal only: ctrl=0,0,0; comp=41,42,43; tokenCount=3 -> outputs 41,42,43; done=1; outCount=3.
- Simple match: "ABCABC" encoded as 3 literals plus a match with length=3, offset=3 (bytes 0x30,0x03) -> outputs 41,42,43,41,42,43; outCount=6.
- Overlap: literal 61 plus a match with length=4, offset=1 -> outputs 61,61,61,61,61; done=1.
- Back-pressure: the simple-match case with outReady toggled every other cycle -> identical byte sequence, outByte stable while stalled, no duplicated or dropped bytes.
- Errors: a first token that is a match with offset=5 while outCount=0 -> error=1, done=0, no outValid. Separately, length=0 -> error=1.
- Boundaries: tokenCount=0 -> done next cycle, outValid never high. Reset asserted mid-COPY -> all outputs 0 next cycle; a fresh start then decodes correctly.
